// File: rtl/snake_food_ctrl.sv
// snake_food_ctrl
//   Food placement and eat detection for the snake game. Watches the head
//   position published by snake_core and raises a grow request when the head
//   lands on the food. It then places new food pseudo-randomly inside the
//   play-field border, never on the head, and keeps a saturating score.
//
// Ports
//   clk_pix    in   pixel/system clock (only clock)
//   rst        in   synchronous active-high reset, dominates all inputs
//   tick       in   game tick strobe shared with snake_core
//   head_x     in   head x in pixels
//   head_y     in   head y in pixels
//   eat_evt    out  grow request to snake_core
//   food_x     out  food x in pixels
//   food_y     out  food y in pixels
//   food_valid out  food is placed and should be drawn
//   score      out  foods eaten, saturating
//
// Handshake (eat_evt): valid/ready style where eat_evt is "valid" and the
// next cycle with tick=1 is "ready". eat_evt rises on the detect cycle and
// stays high up to and including the first cycle with tick=1. It drops on the
// clock after that tick. A new detect on the same clock wins over the clear.
// Each eaten food therefore yields exactly one growth.
module snake_food_ctrl #(
  parameter int          CELL      = 10,
  parameter int          GRID_W    = 64,
  parameter int          GRID_H    = 48,
  parameter int          INIT_FX   = 400,
  parameter int          INIT_FY   = 240,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SCORE_W   = 8
) (
  input  logic               clk_pix,
  input  logic               rst,
  input  logic               tick,
  input  logic [9:0]         head_x,
  input  logic [8:0]         head_y,
  output logic               eat_evt,
  output logic [9:0]         food_x,
  output logic [8:0]         food_y,
  output logic               food_valid,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic {PLACED, SPAWN} state_e;

  localparam logic [15:0]        LFSR_MASK = 16'hB400;
  localparam logic [9:0]         CELL_X    = 10'(CELL);
  localparam logic [8:0]         CELL_Y    = 9'(CELL);
  localparam logic [9:0]         FAR_X     = 10'((GRID_W - 2) * CELL);
  localparam logic [8:0]         FAR_Y     = 9'((GRID_H - 2) * CELL);
  localparam logic [9:0]         INIT_X    = 10'(INIT_FX);
  localparam logic [8:0]         INIT_Y    = 9'(INIT_FY);
  localparam logic [5:0]         COL_MAX   = 6'(GRID_W - 2);
  localparam logic [5:0]         ROW_MAX   = 6'(GRID_H - 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               tick_dly_q;
  logic [7:0]         attempt_q, attempt_d;
  logic               eat_q, eat_d;
  logic [9:0]         fx_q, fx_d;
  logic [8:0]         fy_q, fy_d;
  logic               valid_q, valid_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic [5:0] cand_col, cand_row;
  logic [9:0] cand_x;
  logic [8:0] cand_y;
  logic       cand_ok;
  logic       detect;
  logic       head_at_cell;

  // Candidate cell from the LFSR, one per clock while spawning.
  assign cand_col = lfsr_q[5:0];
  assign cand_row = lfsr_q[13:8];
  assign cand_x   = 10'(cand_col) * CELL_X;
  assign cand_y   = 9'(cand_row) * CELL_Y;
  assign cand_ok  = (cand_col >= 6'd1) && (cand_col <= COL_MAX) &&
                    (cand_row >= 6'd1) && (cand_row <= ROW_MAX) &&
                    !((cand_x == head_x) && (cand_y == head_y));

  // The head ports are only trusted in the cycle after a tick, when
  // snake_core has just moved the head.
  assign detect = tick_dly_q && valid_q && (head_x == fx_q) && (head_y == fy_q);

  assign head_at_cell = (head_x == CELL_X) && (head_y == CELL_Y);

  always_comb begin
    state_d   = state_q;
    attempt_d = attempt_q;
    eat_d     = eat_q;
    fx_d      = fx_q;
    fy_d      = fy_q;
    valid_d   = valid_q;
    score_d   = score_q;
    // Galois right shift; a non-zero seed never reaches zero.
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    // The clear is independent of FSM state; a detect below overrides it.
    if (eat_q && tick) begin
      eat_d = 1'b0;
    end

    case (state_q)
      PLACED: begin
        if (detect) begin
          eat_d     = 1'b1;
          valid_d   = 1'b0;
          attempt_d = 8'd0;
          state_d   = SPAWN;
          if (score_q != SCORE_MAX) begin
            score_d = score_q + SCORE_ONE;
          end
        end
      end
      SPAWN: begin
        if (cand_ok) begin
          fx_d    = cand_x;
          fy_d    = cand_y;
          valid_d = 1'b1;
          state_d = PLACED;
        end else if (attempt_q == 8'hFF) begin
          // 256th consecutive reject: deterministic corner, away from head.
          fx_d    = head_at_cell ? FAR_X : CELL_X;
          fy_d    = head_at_cell ? FAR_Y : CELL_Y;
          valid_d = 1'b1;
          state_d = PLACED;
        end else begin
          attempt_d = attempt_q + 8'd1;
        end
      end
      default: state_d = PLACED;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q    <= PLACED;
      lfsr_q     <= LFSR_SEED;
      tick_dly_q <= 1'b0;
      attempt_q  <= 8'd0;
      eat_q      <= 1'b0;
      fx_q       <= INIT_X;
      fy_q       <= INIT_Y;
      valid_q    <= 1'b1;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      tick_dly_q <= tick;
      attempt_q  <= attempt_d;
      eat_q      <= eat_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      valid_q    <= valid_d;
      score_q    <= score_d;
    end
  end

  assign eat_evt    = eat_q;
  assign food_x     = fx_q;
  assign food_y     = fy_q;
  assign food_valid = valid_q;
  assign score      = score_q;

endmodule

// File: tb/tb_snake_food_ctrl.sv
// tb_snake_food_ctrl
//   Directed bench for snake_food_ctrl (SCORE_W=2 so saturation is reachable).
//   A reference LFSR stepped from the same reset predicts every placement.
module tb_snake_food_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk_pix = 1'b0;
  logic       rst;
  logic       tick;
  logic [9:0] head_x;
  logic [8:0] head_y;
  logic       eat_evt;
  logic [9:0] food_x;
  logic [8:0] food_y;
  logic       food_valid;
  logic [1:0] score;

  always #5 clk_pix = ~clk_pix;

  snake_food_ctrl #(
    .CELL(10), .GRID_W(64), .GRID_H(48), .INIT_FX(400), .INIT_FY(240),
    .LFSR_SEED(16'hACE1), .SCORE_W(2)
  ) dut (
    .clk_pix(clk_pix), .rst(rst), .tick(tick),
    .head_x(head_x), .head_y(head_y),
    .eat_evt(eat_evt), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .score(score)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int exp_score;

  // ---------------- reference LFSR ----------------
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk_pix) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_pix);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Walk candidates from the LFSR value seen on the first SPAWN clock.
  task automatic predict(input logic [15:0] l0, output int px, output int py, output int cyc);
    logic [15:0] l;
    int col, row;
    l = l0;
    for (int k = 0; k < 256; k++) begin
      col = int'(l[5:0]);
      row = int'(l[13:8]);
      if (col >= 1 && col <= 62 && row >= 1 && row <= 46 &&
          !(col * 10 == int'(head_x) && row * 10 == int'(head_y))) begin
        px  = col * 10;
        py  = row * 10;
        cyc = k + 1;
        return;
      end
      l = lfsr_next(l);
    end
    cyc = 256;
    if (head_x == 10'd10 && head_y == 9'd10) begin
      px = 620; py = 460;
    end else begin
      px = 10; py = 10;
    end
  endtask

  // Tick with the head already positioned on the food; checks detect timing.
  task automatic trigger_eat();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("eat_not_early", eat_evt, 0);
    step(1);
    exp_score = (exp_score == 3) ? 3 : exp_score + 1;
    check("eat_set", eat_evt, 1);
    check("score", score, exp_score);
    check("valid_drop", food_valid, 0);
  endtask

  task automatic check_placement(input int px, input int py, input int cyc);
    int c;
    c = 0;
    while (food_valid !== 1'b1 && c < 300) begin
      step(1);
      c++;
    end
    check("respawn_valid", food_valid, 1);
    check("respawn_lat", c, cyc);
    check("food_x", food_x, px);
    check("food_y", food_y, py);
    check("in_bounds", (food_x % 10 == 0) && (food_x >= 10) && (food_x <= 620) &&
                       (food_y % 10 == 0) && (food_y >= 10) && (food_y <= 460), 1);
    check("not_on_head", (food_x != head_x) || (food_y != head_y), 1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int px, py, cyc;
    logic [9:0] fbx;
    logic [8:0] fby;

    rst = 1'b1; tick = 1'b0; head_x = '0; head_y = '0; exp_score = 0;
    step(2);
    rst = 1'b0;
    step(3);
    check("rst_food_x", food_x, 400);
    check("rst_food_y", food_y, 240);
    check("rst_valid", food_valid, 1);
    check("rst_eat", eat_evt, 0);
    check("rst_score", score, 0);

    // First eat at the initial food position.
    head_x = 10'd400; head_y = 9'd240;
    trigger_eat();
    predict(m_lfsr, px, py, cyc);
    check_placement(px, py, cyc);

    // eat_evt waits for the next tick, then clears on the following clock.
    step(20);
    check("eat_hold", eat_evt, 1);
    tick = 1'b1;
    check("eat_in_tick", eat_evt, 1);
    step(1);
    tick = 1'b0;
    check("eat_cleared", eat_evt, 0);
    step(1);
    check("no_false_eat", eat_evt, 0);
    check("score_kept", score, 1);

    // Many eats with the head parked on each new food; score saturates at 3.
    for (int i = 0; i < 1000; i++) begin
      head_x = food_x; head_y = food_y;
      trigger_eat();
      predict(m_lfsr, px, py, cyc);
      check_placement(px, py, cyc);
    end
    check("score_sat", score, 3);

    // Only out-of-range candidates: fallback corners, alternating with head.
    force dut.lfsr_q = 16'hFFFF;
    for (int j = 0; j < 2; j++) begin
      head_x = food_x; head_y = food_y;
      if (head_x == 10'd10 && head_y == 9'd10) begin
        fbx = 10'd620; fby = 9'd460;
      end else begin
        fbx = 10'd10; fby = 9'd10;
      end
      trigger_eat();
      check_placement(int'(fbx), int'(fby), 256);
    end
    release dut.lfsr_q;

    // Reset in the middle of SPAWN.
    head_x = food_x; head_y = food_y;
    trigger_eat();
    rst = 1'b1;
    step(1);
    check("rst_spawn_x", food_x, 400);
    check("rst_spawn_y", food_y, 240);
    check("rst_spawn_valid", food_valid, 1);
    check("rst_spawn_eat", eat_evt, 0);
    check("rst_spawn_score", score, 0);
    rst = 1'b0;
    exp_score = 0;

    // LFSR restarted from its seed: next placement follows the reference.
    step(2);
    head_x = 10'd400; head_y = 9'd240;
    trigger_eat();
    predict(m_lfsr, px, py, cyc);
    check_placement(px, py, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
